// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_event_ctrl
// Description : Turns the raw PS/2 scan-code byte stream (set 2) into
//               key press/release events held in a first-word-fall-through
//               event FIFO.
//               E0 prefixes mark extended keys, F0 marks a release, the
//               8-byte Pause sequence (E1 ...) is swallowed, and the
//               E0 12 / E0 59 "fake shift" codes are discarded.
//
// Ports       : clk        - sole clock, all logic on posedge
//               reset      - synchronous, active-high
//               scan_code  - received byte, qualified by new_data
//               new_data   - one-cycle strobe per received byte
//               evt_valid  - FIFO head holds an event
//               evt_ready  - consumer pops head when evt_valid & evt_ready
//               evt_code   - key code of head event (0 when empty)
//               evt_ext    - head event was E0-prefixed (0 when empty)
//               evt_break  - head event is a release (0 when empty)
//               evt_count  - FIFO occupancy
//               overflow   - sticky: an event was dropped on a full FIFO
//
// Options     : PS2_TYPEMATIC_FILTER_EN - when defined, a held-key bitmap
//               suppresses typematic repeat presses of keys already down.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    scan_code,
    input  logic                          new_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Decoder state
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       push_q;
    logic [7:0] push_code_q;
    logic       push_ext_q;
    logic       push_brk_q;

    logic       w_emit;
    logic       w_ext;
    logic       w_brk;
    logic       w_drop;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        w_emit  = 1'b0;
        w_ext   = 1'b0;
        w_brk   = 1'b0;
        if (new_data) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (scan_code == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (scan_code == 8'hE1) begin
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end else if (scan_code == 8'h00 || scan_code == 8'hAA ||
                                 scan_code == 8'hEE || scan_code == 8'hFA ||
                                 scan_code == 8'hFE || scan_code == 8'hFF) begin
                        // Controller/keyboard status bytes, not keys.
                        state_d = S_IDLE;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                S_EXT: begin
                    state_d = S_IDLE;
                    if (scan_code == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (!is_fake_shift(scan_code) && !is_prefix(scan_code)) begin
                        w_emit = 1'b1;
                        w_ext  = 1'b1;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (!is_prefix(scan_code)) begin
                        w_emit = 1'b1;
                        w_brk  = 1'b1;
                    end
                end
                S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (!is_fake_shift(scan_code) && !is_prefix(scan_code)) begin
                        w_emit = 1'b1;
                        w_ext  = 1'b1;
                        w_brk  = 1'b1;
                    end
                end
                S_SKIP: begin
                    // Counter loaded with 7 on E1: the 7 trailing Pause bytes
                    // are consumed, returning to IDLE as it reaches zero.
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = S_IDLE;
                        skip_d  = 3'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    // One bit per {ext, code}: set while the key is held down.
    logic [511:0] held_q;
    assign w_drop = w_emit && !w_brk && held_q[{w_ext, scan_code}];
`else
    assign w_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            skip_q      <= 3'd0;
            push_q      <= 1'b0;
            push_code_q <= 8'h00;
            push_ext_q  <= 1'b0;
            push_brk_q  <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            // Decoded event is pushed into the FIFO on the following cycle.
            push_q      <= w_emit && !w_drop;
            push_code_q <= scan_code;
            push_ext_q  <= w_ext;
            push_brk_q  <= w_brk;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (w_emit) begin
                held_q[{w_ext, scan_code}] <= !w_brk;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] wr_ptr_q;
    logic [c_AW-1:0] rd_ptr_q;
    logic [c_CW-1:0] count_q;
    logic            overflow_q;

    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic [9:0]      w_head;

    assign w_full = (count_q == c_FULL);
    assign w_pop  = (count_q != '0) && evt_ready;
    // A push into a full FIFO is still accepted when a pop frees a slot.
    assign w_wr   = push_q && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= {push_code_q, push_ext_q, push_brk_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   count_q <= count_q + c_CW'(1);
                2'b01:   count_q <= count_q - c_CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_q && !w_wr) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign w_head    = mem_q[rd_ptr_q];
    assign evt_valid = (count_q != '0);
    assign evt_code  = evt_valid ? w_head[9:2] : 8'h00;
    assign evt_ext   = evt_valid ? w_head[1]   : 1'b0;
    assign evt_break = evt_valid ? w_head[0]   : 1'b0;
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_event_ctrl
// Description : Self-checking bench for ps2_key_event_ctrl. A byte-sequence
//               parser plus queue-based FIFO model predicts every output on
//               every cycle; directed sequences pin the model with literal
//               event lists, then randomized traffic runs against the model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    scan_code = 8'h00;
    logic          new_data = 1'b0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [7:0]    evt_code;
    logic          evt_ext;
    logic          evt_break;
    logic [CW-1:0] evt_count;
    logic          overflow;

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_code (scan_code),
        .new_data  (new_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .evt_count (evt_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte-sequence parser + event queue
    // Events are encoded {code[7:0], ext, brk}.
    // ------------------------------------------------------------------
    logic [9:0] m_q[$];
    logic [7:0] m_prefix[$];
    int         m_skip = 0;
    bit         m_pend = 1'b0;
    logic [9:0] m_pend_evt = '0;
    bit         m_ovf = 1'b0;
    bit         m_held[512];

    function automatic bit is_status(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE ||
               b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction

    function automatic bit model_decode(input logic [7:0] b, output logic [9:0] ev);
        bit ext, brk;
        ev = '0;
        if (m_skip > 0) begin
            m_skip--;
            return 1'b0;
        end
        if (m_prefix.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) begin
                m_prefix.push_back(b);
                return 1'b0;
            end
            if (b == 8'hE1) begin
                m_skip = 7;
                return 1'b0;
            end
            if (is_status(b)) return 1'b0;
            ev = {b, 1'b0, 1'b0};
            return 1'b1;
        end
        ext = (m_prefix[0] == 8'hE0);
        brk = (m_prefix[m_prefix.size()-1] == 8'hF0);
        if (b == 8'hF0 && ext && !brk) begin
            m_prefix.push_back(b);
            return 1'b0;
        end
        m_prefix.delete();
        if (b == 8'hE0 || b == 8'hE1 || b == 8'hF0) return 1'b0;
        if (ext && (b == 8'h12 || b == 8'h59)) return 1'b0;
        ev = {b, ext, brk};
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        bit         pop, full, got_ev;
        logic [9:0] ev;
        pop  = (m_q.size() > 0) && evt_ready;
        full = (m_q.size() == DEPTH);
        if (reset) begin
            m_q.delete();
            m_prefix.delete();
            m_skip = 0;
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            foreach (m_held[i]) m_held[i] = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_pend) begin
                if (!full || pop) m_q.push_back(m_pend_evt);
                else m_ovf = 1'b1;
            end
            m_pend = 1'b0;
            if (new_data) begin
                got_ev = model_decode(scan_code, ev);
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (got_ev) begin
                    if (!ev[0] && m_held[ev[9:1]]) got_ev = 1'b0;
                    else m_held[ev[9:1]] = !ev[0];
                end
`endif
                m_pend     = got_ev;
                m_pend_evt = ev;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model, and capture of popped events
    // ------------------------------------------------------------------
    logic [9:0] got[$];

    always @(negedge clk) begin : compare
        logic [9:0] exp_head;
        exp_head = (m_q.size() != 0) ? m_q[0] : 10'h000;
        if (chk_en) begin
            check("valid",    32'(evt_valid), 32'(m_q.size() != 0));
            check("count",    32'(evt_count), m_q.size());
            check("head",     {22'd0, evt_code, evt_ext, evt_break}, 32'(exp_head));
            check("overflow", 32'(overflow), 32'(m_ovf));
        end
        if (evt_valid && evt_ready) got.push_back({evt_code, evt_ext, evt_break});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [9:0] exp_l[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b, input bit chk_lat);
        scan_code = b;
        new_data  = 1'b1;
        tick();
        new_data  = 1'b0;
        if (chk_lat) begin
            check("lat_cycle1_valid", 32'(evt_valid), 32'd0);
            tick();
            check("lat_cycle2_valid", 32'(evt_valid), 32'd1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_list(input string name);
        check({name, "_len"}, got.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < got.size(); i++)
            check(name, 32'(got[i]), 32'(exp_l[i]));
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            0, 1:    return 8'hE0;
            2, 3:    return 8'hF0;
            4:       return 8'hE1;
            5:       return 8'h12;
            6:       return 8'h59;
            7:       return 8'hAA;
            8:       return 8'h00;
            9, 10, 11, 12: return 8'($urandom_range(1, 6));
            default: return 8'($urandom_range(1, 8'h7F));
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int mode;
        idle(2);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_valid",    32'(evt_valid), 32'd0);
        check("rst_count",    32'(evt_count), 32'd0);
        check("rst_code",     32'(evt_code),  32'd0);
        check("rst_ext",      32'(evt_ext),   32'd0);
        check("rst_break",    32'(evt_break), 32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);

        // Press/release, extended keys, fake shift, Pause sequence
        evt_ready = 1'b1;
        got.delete();
        send(8'h1C, 1'b1);
        idle(3);
        send(8'hF0, 1'b0); send(8'h1C, 1'b1);
        idle(3);
        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        send(8'hE0, 1'b0); send(8'h12, 1'b0);
        idle(4);
        send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
        send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
        send(8'h29, 1'b0);
        idle(4);
        exp_l.delete();
        exp_l.push_back({8'h1C, 1'b0, 1'b0});
        exp_l.push_back({8'h1C, 1'b0, 1'b1});
        exp_l.push_back({8'h75, 1'b1, 1'b0});
        exp_l.push_back({8'h75, 1'b1, 1'b1});
        exp_l.push_back({8'h29, 1'b0, 1'b0});
        check_list("seq_events");

        // Overflow: 9 distinct presses into a depth-8 FIFO with no consumer
        do_reset();
        evt_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
        idle(3);
        check("ovf_count", 32'(evt_count), 32'd8);
        check("ovf_flag",  32'(overflow),  32'd1);
        got.delete();
        evt_ready = 1'b1;
        idle(12);
        exp_l.delete();
        for (int i = 1; i <= 8; i++) exp_l.push_back({8'(i), 1'b0, 1'b0});
        check_list("ovf_order");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset discards a pending break prefix
        do_reset();
        got.delete();
        send(8'hF0, 1'b0);
        do_reset();
        check("rst_mid_count", 32'(evt_count), 32'd0);
        send(8'h1C, 1'b0);
        idle(4);
        exp_l.delete();
        exp_l.push_back({8'h1C, 1'b0, 1'b0});
        check_list("rst_mid_events");

        // Typematic repeats
        do_reset();
        got.delete();
        send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
        idle(4);
        exp_l.delete();
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_l.push_back({8'h1C, 1'b0, 1'b0});
        exp_l.push_back({8'h1C, 1'b0, 1'b1});
        exp_l.push_back({8'h1C, 1'b0, 1'b0});
`else
        exp_l.push_back({8'h1C, 1'b0, 1'b0});
        exp_l.push_back({8'h1C, 1'b0, 1'b0});
        exp_l.push_back({8'h1C, 1'b0, 1'b0});
        exp_l.push_back({8'h1C, 1'b0, 1'b1});
        exp_l.push_back({8'h1C, 1'b0, 1'b0});
`endif
        check_list("typematic");

        // Randomized traffic against the model
        do_reset();
        mode = 0;
        for (int c = 0; c < 6000; c++) begin
            if (c % 250 == 0) mode = $urandom_range(0, 2);
            reset     = ($urandom_range(0, 599) == 0);
            new_data  = ($urandom_range(0, 3) != 0);
            scan_code = rand_byte();
            case (mode)
                0:       evt_ready = 1'b1;
                1:       evt_ready = ($urandom_range(0, 1) == 1);
                default: evt_ready = ($urandom_range(0, 9) == 0);
            endcase
            tick();
        end
        reset     = 1'b0;
        new_data  = 1'b0;
        evt_ready = 1'b1;
        idle(DEPTH + 4);
        check("drain_valid", 32'(evt_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
